// File: rtl/debounce_bank.sv
// Per-channel input synchroniser, counter-based debounce filter, edge pulses,
// and long-press / auto-repeat pulse generation for a bank of buttons.
module debounce_bank #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_COUNT     = 50000,
    parameter int HOLD_COUNT   = 25000000,
    parameter int REPEAT_COUNT = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal_i,
    output logic [CHANNELS-1:0] signal_f,
    output logic [CHANNELS-1:0] rise_p,
    output logic [CHANNELS-1:0] fall_p,
    output logic [CHANNELS-1:0] hold_p,
    output logic [CHANNELS-1:0] rpt_p
);

    localparam int DB_W    = $clog2(DB_COUNT + 1);
    localparam int HOLD_W  = $clog2(HOLD_COUNT + 1);
    localparam int RPT_MAX = (REPEAT_COUNT > 0) ? REPEAT_COUNT - 1 : 0;
    localparam int RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_COUNT);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(RPT_MAX);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   sync_out;
        logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
        logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
        logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
        logic                   sig_f_q, sig_f_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   hold_q, hold_d;
        logic                   rpt_q, rpt_d;

        assign sync_out = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d     = {sync_q[SYNC_STAGES-2:0], signal_i[g]};
            sig_f_d    = sig_f_q;
            db_cnt_d   = '0;
            rise_d     = 1'b0;
            fall_d     = 1'b0;
            hold_cnt_d = '0;
            rpt_cnt_d  = '0;
            hold_d     = 1'b0;
            rpt_d      = 1'b0;

            if (sync_out != sig_f_q) begin
                if (db_cnt_q == DB_LAST) begin
                    sig_f_d = sync_out;
                    rise_d  = sync_out;
                    fall_d  = ~sync_out;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            // Timers run only while the level stays high across this edge, so a
            // release clears them on the very edge that raises fall_p.
            if (sig_f_q && sig_f_d) begin
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    hold_d     = (hold_cnt_q == HOLD_LAST);
                end else begin
                    hold_cnt_d = hold_cnt_q;
                    if (REPEAT_COUNT > 0) begin
                        if (rpt_cnt_q == RPT_LAST) begin
                            rpt_d = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + 1'b1;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q     <= '0;
                db_cnt_q   <= '0;
                hold_cnt_q <= '0;
                rpt_cnt_q  <= '0;
                sig_f_q    <= 1'b0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
                hold_q     <= 1'b0;
                rpt_q      <= 1'b0;
            end else begin
                sync_q     <= sync_d;
                db_cnt_q   <= db_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                rpt_cnt_q  <= rpt_cnt_d;
                sig_f_q    <= sig_f_d;
                rise_q     <= rise_d;
                fall_q     <= fall_d;
                hold_q     <= hold_d;
                rpt_q      <= rpt_d;
            end
        end

        assign signal_f[g] = sig_f_q;
        assign rise_p[g]   = rise_q;
        assign fall_p[g]   = fall_q;
        assign hold_p[g]   = hold_q;
        assign rpt_p[g]    = rpt_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed scenarios plus random bouncing inputs, checked every cycle against
// a history-based reference model of the debounce/hold/repeat rules.
module tb_debounce_bank;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DB   = 8;
    localparam int HOLD = 20;
    localparam int RPT  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] signal_i = '0;
    logic [CH-1:0] signal_f, rise_p, fall_p, hold_p, rpt_p;

    int checks = 0;
    int errors = 0;

    debounce_bank #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .DB_COUNT    (DB),
        .HOLD_COUNT  (HOLD),
        .REPEAT_COUNT(RPT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .signal_i(signal_i),
        .signal_f(signal_f),
        .rise_p  (rise_p),
        .fall_p  (fall_p),
        .hold_p  (hold_p),
        .rpt_p   (rpt_p)
    );

    always #5 clk = ~clk;

    // Reference model: raw input history per channel, filtered level, rise edge index.
    bit            raw [CH][$];
    logic [CH-1:0] mf = '0;
    int            rise_edge [CH];
    int            ecnt = 0;
    logic [CH-1:0] exp_f, exp_rise, exp_fall, exp_hold, exp_rpt;

    task automatic model_step(input logic [CH-1:0] in, input logic r);
        exp_rise = '0;
        exp_fall = '0;
        exp_hold = '0;
        exp_rpt  = '0;
        if (r) begin
            mf   = '0;
            ecnt = 0;
            for (int c = 0; c < CH; c++) begin
                raw[c].delete();
                for (int k = 0; k < SYNC + DB; k++) raw[c].push_back(1'b0);
            end
        end else begin
            ecnt++;
            for (int c = 0; c < CH; c++) begin
                bit all_diff;
                raw[c].push_back(in[c]);
                if (raw[c].size() > 64) void'(raw[c].pop_front());
                // The level flips once the last DB values seen past the synchroniser all disagree with it.
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    if (raw[c][raw[c].size() - 1 - SYNC - k] == mf[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    mf[c] = ~mf[c];
                    if (mf[c]) begin
                        exp_rise[c]  = 1'b1;
                        rise_edge[c] = ecnt;
                    end else begin
                        exp_fall[c] = 1'b1;
                    end
                end else if (mf[c]) begin
                    int t;
                    t = ecnt - rise_edge[c];
                    if (t == HOLD) exp_hold[c] = 1'b1;
                    if (RPT > 0 && t > HOLD && ((t - HOLD) % RPT) == 0) exp_rpt[c] = 1'b1;
                end
            end
        end
        exp_f = mf;
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    task automatic tick(input logic [CH-1:0] in, input logic r);
        signal_i = in;
        rst      = r;
        @(posedge clk);
        model_step(in, r);
        #1;
        chk("signal_f", signal_f, exp_f);
        chk("rise_p", rise_p, exp_rise);
        chk("fall_p", fall_p, exp_fall);
        chk("hold_p", hold_p, exp_hold);
        chk("rpt_p", rpt_p, exp_rpt);
        chk("rise_fall_excl", rise_p & fall_p, '0);
        chk("hold_rpt_excl", hold_p & rpt_p, '0);
    endtask

    initial begin
        logic [CH-1:0] lvl;
        int            run [CH];

        // Reset state
        tick('0, 1'b1);
        tick('0, 1'b1);
        chk("reset_signal_f", signal_f, '0);

        // Clean step on ch0
        for (int i = 1; i <= 14; i++) begin
            tick(4'b0001, 1'b0);
            if (i == 9)  chk("s1_rise_e9", rise_p, 4'b0000);
            if (i == 10) chk("s1_rise_e10", rise_p, 4'b0001);
            if (i == 10) chk("s1_f_e10", signal_f, 4'b0001);
            if (i == 11) chk("s1_rise_e11", rise_p, 4'b0000);
        end

        // ch1 bounce: 5 x (7 high, 2 low), then stable high from edge 46
        tick('0, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            tick((i <= 45 && ((i - 1) % 9) >= 7) ? 4'b0000 : 4'b0010, 1'b0);
            if (i == 54) chk("s2_f_e54", signal_f, 4'b0000);
            if (i == 55) chk("s2_rise_e55", rise_p, 4'b0010);
        end

        // ch2 long press: rise at 10, hold 30, repeat 35/40/45, fall 50
        tick('0, 1'b1);
        for (int i = 1; i <= 70; i++) begin
            tick((i <= 40) ? 4'b0100 : 4'b0000, 1'b0);
            if (i == 30) chk("s3_hold_e30", hold_p, 4'b0100);
            if (i == 35) chk("s3_rpt_e35", rpt_p, 4'b0100);
            if (i == 40) chk("s3_rpt_e40", rpt_p, 4'b0100);
            if (i == 45) chk("s3_rpt_e45", rpt_p, 4'b0100);
            if (i == 50) chk("s3_fall_e50", fall_p, 4'b0100);
            if (i == 50) chk("s3_rpt_e50", rpt_p, 4'b0000);
        end

        // ch3 short press: no hold/repeat, one fall at edge 25
        tick('0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            tick((i <= 15) ? 4'b1000 : 4'b0000, 1'b0);
            if (i == 25) chk("s4_fall_e25", fall_p, 4'b1000);
            if (i == 30) chk("s4_hold_e30", hold_p, 4'b0000);
        end

        // All channels stepped together
        tick('0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick(4'b1111, 1'b0);
            if (i == 10) chk("s5_rise_all", rise_p, 4'b1111);
        end

        // Reset mid-debounce at count 5, input kept high
        tick('0, 1'b1);
        for (int i = 1; i <= 7; i++) tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b1);
        chk("s6_reset_f", signal_f, '0);
        chk("s6_reset_rise", rise_p, '0);
        for (int i = 1; i <= 12; i++) begin
            tick(4'b0001, 1'b0);
            if (i == 9)  chk("s6_rise_e9", rise_p, 4'b0000);
            if (i == 10) chk("s6_rise_e10", rise_p, 4'b0001);
        end

        // Random bouncing runs with occasional reset
        lvl = '0;
        for (int c = 0; c < CH; c++) run[c] = $urandom_range(1, 45);
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                run[c]--;
                if (run[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : $urandom_range(1, 60);
                end
            end
            tick(lvl, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
